gated_latch_bank: RTL and testbench

//  Multi-channel, synchronous successor to the single-bit level-sensitive latch.

---
 rtl/gated_latch_bank.sv | 111 +++++++++++
 tb/tb_gated_latch_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gated_latch_bank.sv
// rtl/gated_latch_bank.sv - multi-channel clocked gated latch with post-freeze hold window
// Each channel runs a CLOSED/OPEN/HOLD FSM; re-open attempts during HOLD are flagged and counted.
module gated_latch_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       gate,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       held,
  output logic [CHANNELS-1:0]       violation,
  output logic [7:0]                viol_count
);

  localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                    state_q [CHANNELS];
  state_t                    state_d [CHANNELS];
  logic   [CW-1:0]           cnt_q   [CHANNELS];
  logic   [CW-1:0]           cnt_d   [CHANNELS];
  logic   [CHANNELS*WIDTH-1:0] q_d;
  logic   [CHANNELS-1:0]     held_d;
  logic   [CHANNELS-1:0]     viol_d;
  logic   [9:0]              viol_sum;
  logic   [7:0]              viol_count_d;

  always_comb begin
    q_d      = q;
    held_d   = '1;
    viol_d   = '0;
    viol_sum = {2'b00, viol_count};
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear[i]) begin
        state_d[i]               = CLOSED;
        cnt_d[i]                 = '0;
        q_d[i*WIDTH +: WIDTH]    = '0;
      end else begin
        case (state_q[i])
          CLOSED: begin
            if (gate[i]) begin
              state_d[i]            = OPEN;
              q_d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
            end
          end
          OPEN: begin
            if (gate[i]) begin
              q_d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
            end else if (HOLD_CYCLES == 0) begin
              state_d[i] = CLOSED;
            end else begin
              state_d[i] = HOLD;
              cnt_d[i]   = HOLD_INIT;
            end
          end
          HOLD: begin
            // gate is only observed here to flag the attempt; it never reopens from HOLD
            viol_d[i] = gate[i];
            if (cnt_q[i] == '0) begin
              state_d[i] = CLOSED;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
          default: begin
            state_d[i] = CLOSED;
            cnt_d[i]   = '0;
          end
        endcase
      end
      held_d[i] = (state_d[i] != OPEN);
      viol_sum  = viol_sum + {9'd0, viol_d[i]};
    end
    viol_count_d = (viol_sum > 10'd255) ? 8'd255 : viol_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= CLOSED;
        cnt_q[i]   <= '0;
      end
      q          <= '0;
      held       <= '1;
      violation  <= '0;
      viol_count <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      q          <= q_d;
      held       <= held_d;
      violation  <= viol_d;
      viol_count <= viol_count_d;
    end
  end

endmodule

// File: tb/tb_gated_latch_bank.sv
// tb/tb_gated_latch_bank.sv - directed and randomized bench for gated_latch_bank
// Reference model tracks each channel as open/closed plus the last edge of its hold window.
module tb_gated_latch_bank;

  localparam int W = 8;
  localparam int C = 4;
  localparam int H = 3;

  logic           clock;
  logic           reset;
  logic [C-1:0]   gate;
  logic [C-1:0]   clear;
  logic [C*W-1:0] d;
  logic [C*W-1:0] q;
  logic [C-1:0]   held;
  logic [C-1:0]   violation;
  logic [7:0]     viol_count;

  int vectors     = 0;
  int miscompares = 0;

  int m_q    [C];
  bit m_open [C];
  int m_rel  [C];
  bit m_viol [C];
  int m_count;
  int edge_no;

  gated_latch_bank #(.WIDTH(W), .CHANNELS(C), .HOLD_CYCLES(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .gate       (gate),
    .clear      (clear),
    .d          (d),
    .q          (q),
    .held       (held),
    .violation  (violation),
    .viol_count (viol_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_q[i] = 0; m_open[i] = 0; m_rel[i] = -1; m_viol[i] = 0;
    end
    m_count = 0;
  endtask

  // A channel frozen at edge k is in its hold window for edges k+1 .. k+H.
  task automatic model_edge();
    int n;
    edge_no++;
    if (reset) begin
      model_reset();
      return;
    end
    n = 0;
    for (int i = 0; i < C; i++) begin
      m_viol[i] = 0;
      if (clear[i]) begin
        m_q[i] = 0; m_open[i] = 0; m_rel[i] = -1;
      end else if (edge_no <= m_rel[i]) begin
        m_viol[i] = gate[i];
        n += int'(gate[i]);
      end else if (m_open[i]) begin
        if (gate[i]) m_q[i] = int'(d[i*W +: W]);
        else begin
          m_open[i] = 0;
          m_rel[i]  = edge_no + H;
        end
      end else if (gate[i]) begin
        m_open[i] = 1;
        m_q[i]    = int'(d[i*W +: W]);
      end
    end
    m_count = (m_count + n > 255) ? 255 : m_count + n;
  endtask

  task automatic tick();
    logic [C*W-1:0] eq;
    logic [C-1:0]   eh, ev;
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < C; i++) begin
      eq[i*W +: W] = W'(m_q[i]);
      eh[i]        = ~m_open[i];
      ev[i]        = m_viol[i];
    end
    chk("q", 32'(q), 32'(eq));
    chk("held", 32'(held), 32'(eh));
    chk("violation", 32'(violation), 32'(ev));
    chk("viol_count", 32'(viol_count), 32'(m_count));
  endtask

  task automatic idle(input int n);
    gate = '0; clear = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int r;
    int nb;
    edge_no = 0;
    model_reset();
    reset = 1'b1; clear = '0; gate = 4'hF; d = $urandom;

    // reset with gates open
    tick(); d = $urandom; tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_held", 32'(held), 32'hF);
    chk("rst_viol", 32'(violation), 32'h0);
    chk("rst_count", 32'(viol_count), 32'h0);
    reset = 1'b0;

    // ch0 transparent, then freeze
    gate = 4'h1; d = 32'h0000_0011; tick();
    chk("ch0_q_e1", 32'(q[7:0]), 32'h11);
    chk("ch0_held_e1", 32'(held[0]), 32'h0);
    d = 32'h0000_0022; tick();
    chk("ch0_q_e2", 32'(q[7:0]), 32'h22);
    d = 32'h0000_0033; tick();
    chk("ch0_q_e3", 32'(q[7:0]), 32'h33);
    gate = 4'h0; d = 32'h0000_0044; tick();
    chk("ch0_q_e4", 32'(q[7:0]), 32'h33);
    chk("ch0_held_e4", 32'(held[0]), 32'h1);

    // violation in the second hold edge
    tick();
    gate = 4'h1; d = 32'h0000_00AA; tick();
    chk("ch0_viol", 32'(violation[0]), 32'h1);
    chk("ch0_frozen", 32'(q[7:0]), 32'h33);
    chk("count_1", 32'(viol_count), 32'h1);
    gate = 4'h0; tick();
    chk("ch0_viol_end", 32'(violation[0]), 32'h0);
    gate = 4'h1; tick();
    chk("ch0_reopen", 32'(q[7:0]), 32'hAA);

    // build the count up toward saturation
    idle(5);
    gate = 4'hF; d = $urandom; tick();
    while (m_count + 12 <= 253) begin
      gate = 4'h0; tick();
      gate = 4'hF; d = $urandom; tick(); tick(); tick();
      tick();
    end
    r = 253 - m_count;
    gate = 4'h0; tick();
    for (int k = 0; k < 3; k++) begin
      nb = (r > 4) ? 4 : r;
      r -= nb;
      gate = 4'((1 << nb) - 1);
      tick();
    end
    chk("count_253", 32'(viol_count), 32'd253);
    gate = 4'hF; d = $urandom; tick();
    gate = 4'h0; tick();
    gate = 4'hF; tick();
    chk("viol_all4", 32'(violation), 32'hF);
    chk("count_sat", 32'(viol_count), 32'd255);
    tick();
    chk("count_stay", 32'(viol_count), 32'd255);

    // clear beats gate
    idle(5);
    gate = 4'h4; d = 32'h005C_0000; tick();
    chk("ch2_open", 32'(q[23:16]), 32'h5C);
    clear = 4'h4; d = 32'h0077_0000; tick();
    chk("ch2_clr_q", 32'(q[23:16]), 32'h00);
    chk("ch2_clr_held", 32'(held[2]), 32'h1);
    clear = 4'h0; tick();
    chk("ch2_after_clr", 32'(q[23:16]), 32'h77);
    chk("count_kept", 32'(viol_count), 32'd255);

    // reset mid-operation
    idle(5);
    gate = 4'hA; d = $urandom; tick();
    gate = 4'h2; d = $urandom; tick();
    reset = 1'b1; tick();
    chk("rst2_q", 32'(q), 32'h0);
    chk("rst2_held", 32'(held), 32'hF);
    chk("rst2_count", 32'(viol_count), 32'h0);
    reset = 1'b0; gate = 4'hF; d = 32'hDEAD_BEEF; tick();
    chk("rst2_resume", 32'(q), 32'hDEAD_BEEF);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      gate  = 4'($urandom);
      clear = 4'($urandom_range(0, 7) == 0 ? $urandom : 0);
      reset = ($urandom_range(0, 99) == 0);
      d     = $urandom;
      tick();
    end
    reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
